seq_multiplier_64bit: RTL and testbench
=======================================

# seq_multiplier_64bit

Multi-cycle unsigned 64×64→128-bit shift-and-add multiplier built around the datapath's 64-bit ripple-carry adder (`adder_64bit`), one add-and-shift iteration per clock. It sits in the execute stage beside the ALU and serves MUL/UMULH-class instructions. A start/ready/done handshake lets control logic stall the pipeline while it runs.

## Interface
Parameters:
- none; width fixed at 64-bit operands, 128-bit product.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
- start  input  1  request a new multiply; sampled only when ready=1
- a  input  64  multiplicand, captured on the accepting edge
- b  input  64  multiplier, captured on the accepting edge
- ready  output  1  high in IDLE and DONE; a start is accepted only when ready=1
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- prod_hi  output  64  product bits [127:64]
- prod_lo  output  64  product bits [63:0]

## Operation
- State register: IDLE, RUN, DONE. Reset value IDLE, and all outputs 0 except ready=1.
- Internal state: mcand[63:0], acc[63:0], mplr[63:0], 7-bit iteration counter cnt.
- Accept (ready & start): mcand←a, acc←0, mplr←b, cnt←0, state←RUN.
- RUN iteration, once per edge:
  - The adder computes {co,sum} = acc + (mplr[0] ? mcand : 0) with ci=0.
  - Shift right as a 129-bit value: {acc,mplr} ← {co,sum,mplr} >> 1, so the new acc = {co,sum[63:1]} and the new mplr = {sum[0],mplr[63:1]}.
  - cnt←cnt+1.
  - When cnt==63 on the current edge, this is the 64th iteration and state←DONE.
- DONE: done=1 for exactly one cycle.
  - Next edge: start=1 accepts a new operation (→RUN); otherwise the state goes →IDLE.
- Outputs: prod_hi=acc and prod_lo=mplr.
  - The result is held stable in DONE and IDLE until the next accept.
  - During RUN the outputs show partial values that are not meaningful.
- start while busy=1: ignored, with no effect on the operation in flight.
- Arithmetic: unsigned only. The co of every add is retained, so the product is exact over the full 128 bits with no overflow.

## Timing
- Accept edge E0. RUN iterations occur on edges E1..E64, and the state enters DONE after E64.
- done and the valid product are visible in the cycle following E64.
- Latency from accept edge to done: 64 cycles. Back-to-back throughput: one multiply per 65 cycles.
- Reset mid-RUN or in DONE: at that edge the block returns to IDLE, acc/mplr/mcand/cnt clear to 0, done=0, and the operation is discarded.
- Reset and start on the same edge: reset wins.
- Combinational path per cycle: one 64-bit ripple add plus the mux. No combinational path from start to any output.

## Configuration
- Macro `MULT_ZERO_BYPASS_EN`.
- Defined:
  - An accept with a==0 or b==0 loads acc←0, mplr←0 and goes straight to DONE.
  - done is high in the cycle after the accepting edge, so latency is 1.
- Undefined:
  - Zero operands take the full 64 iterations.
  - The result is identical (0); only the latency differs.

## Test plan
- Reset, then a=3, b=5, start pulse → done is high exactly 64 cycles after the accept edge; prod_hi=0, prod_lo=15; ready=1 and the outputs hold afterwards.
- a=b=0xFFFF_FFFF_FFFF_FFFF → prod_hi=0xFFFF_FFFF_FFFF_FFFE, prod_lo=0x0000_0000_0000_0001.
- a=0x8000_0000_0000_0000, b=2 → prod_hi=1, prod_lo=0. Then start asserted during the DONE cycle with a=7, b=6 → accepted; the second done arrives 64 cycles later with prod_lo=42.
- During RUN of 3×5, pulse start with a=9, b=9 at iteration 10 → ignored; the result is still 15 at 64 cycles.
- reset at iteration 30 of a run → next cycle: IDLE, ready=1, busy=0, done=0, prod_hi=prod_lo=0. A new 4×4 run then gives 16.
- a=0, b=123: with `MULT_ZERO_BYPASS_EN` → done 1 cycle after the accept edge, product 0. Without it → done after 64 cycles, product 0.

Source files
------------

// File: rtl/seq_multiplier_64bit_if.sv
// Handshake and result bundle for the 64x64 sequential multiplier.
interface seq_multiplier_64bit_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] prod_hi;
    logic [63:0] prod_lo;

    modport master (
        output start, a, b,
        input  ready, busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, prod_hi, prod_lo
    );
endinterface

// File: rtl/seq_multiplier_64bit.sv
// Unsigned 64x64->128 shift-and-add multiplier, one add per clock.
// Optional MULT_ZERO_BYPASS_EN: zero operands finish in one cycle.
module seq_multiplier_64bit (
    input  logic                   clk,
    input  logic                   reset,
    seq_multiplier_64bit_if.slave  mif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] acc_q,   acc_d;
    logic [63:0] mplr_q,  mplr_d;
    logic [6:0]  cnt_q,   cnt_d;

    logic [63:0] addend;
    logic [63:0] sum;
    logic        co;
    logic        accept;

    assign addend    = mplr_q[0] ? mcand_q : 64'd0;
    assign {co, sum} = {1'b0, acc_q} + {1'b0, addend};
    assign accept    = mif.ready & mif.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    mcand_d = mif.a;
                    acc_d   = '0;
                    mplr_d  = mif.b;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if (mif.a == 64'd0 || mif.b == 64'd0) begin
                        mplr_d  = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // 129-bit right shift of {co,sum,mplr}
                acc_d  = {co, sum[63:1]};
                mplr_d = {sum[0], mplr_q[63:1]};
                cnt_d  = cnt_q + 7'd1;
                if (cnt_q == 7'd63) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mif.ready   = (state_q == IDLE) || (state_q == DONE);
    assign mif.busy    = (state_q == RUN);
    assign mif.done    = (state_q == DONE);
    assign mif.prod_hi = acc_q;
    assign mif.prod_lo = mplr_q;
endmodule

// File: tb/tb_seq_multiplier_64bit.sv
// Scoreboard bench for seq_multiplier_64bit: random and directed
// multiplies checked against a plain 128-bit product model.
module tb_seq_multiplier_64bit;
    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [127:0] prod;
        int           due;
    } exp_t;

    exp_t         q[$];
    logic [127:0] last;

    seq_multiplier_64bit_if mif ();

    seq_multiplier_64bit dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int lat(input logic [63:0] a, input logic [63:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 64'd0 || b == 64'd0) return 1;
`endif
        return 64;
    endfunction

    // Monitor: checks results, latency, status flags and result hold
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && cyc > q[0].due) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: no done by cycle %0d (due %0d)",
                         cyc, q[0].due);
                void'(q.pop_front());
            end else if (mif.done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    chk("latency", 128'(cyc), 128'(q[0].due));
                    chk("product", {mif.prod_hi, mif.prod_lo}, q[0].prod);
                    chk("ready_in_done", 128'(mif.ready), 128'd1);
                    last = q[0].prod;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                chk("run_flags", {126'd0, mif.busy, mif.ready}, 128'b10);
            end else if (mif.ready) begin
                chk("hold", {mif.prod_hi, mif.prod_lo}, last);
                chk("idle_busy", 128'(mif.busy), 128'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!mif.ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!mif.ready) begin
            $display("FAIL ready_wait: ready still low after %0d cycles", n);
            $fatal(1, "stuck");
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        int   k;
        exp_t e;
        wait_ready();
        mif.a     = a;
        mif.b     = b;
        mif.start = 1'b1;
        k         = cyc;
        e.prod    = {64'd0, a} * {64'd0, b};
        e.due     = k + 1 + lat(a, b);
        @(posedge clk);
        q.push_back(e);
        #1;
        mif.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() > 0 || !mif.ready || mif.done) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        last = '0;
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(mif.ready), 128'd1);
        chk("rst_busy", 128'(mif.busy), 128'd0);
        chk("rst_done", 128'(mif.done), 128'd0);
        chk("rst_prod", {mif.prod_hi, mif.prod_lo}, 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ra, rb;
        int w;
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        last      = '0;
        reset     = 1'b1;
        mif.start = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        idle(2);
        do_reset();

        issue(64'd3, 64'd5);
        wait_drain();
        idle(4);

        issue('1, '1);
        wait_drain();

        issue(64'h8000_0000_0000_0000, 64'd2);
        w = 0;
        while (!mif.done && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        issue(64'd7, 64'd6);
        wait_drain();

        issue(64'd3, 64'd5);
        idle(9);
        mif.a     = 64'd9;
        mif.b     = 64'd9;
        mif.start = 1'b1;
        idle(1);
        mif.start = 1'b0;
        wait_drain();

        issue(64'd3, 64'd5);
        idle(29);
        do_reset();
        issue(64'd4, 64'd4);
        wait_drain();

        issue(64'd0, 64'd123);
        wait_drain();

        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) ra = '0;
            if (i % 3 == 1) ra = ra >> $urandom_range(0, 63);
            issue(ra, rb);
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
